// File: rtl/bcd_addsub_serial.sv
// Serial BCD adder/subtractor, one digit per clock, LSD first.
// Ports: clk, rst, start/sub/A/B in; busy, done, S, cout, invalid out.
module bcd_addsub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] S,
  output logic                cout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  s_q, s_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sub_q, sub_d;
  logic          c_q, c_d;
  logic          inv_q, inv_d;
  logic          cout_q, cout_d;
  logic          invalid_q, invalid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          inv_in;
  logic [3:0]    dig_a;
  logic [3:0]    dig_b;
  logic [4:0]    t;
  logic [3:0]    digit;
  logic          c_nxt;
  logic [W-1:0]  dig_ext;
  logic          accept;

  always_comb begin
    inv_in = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (A[4*k +: 4] > 4'd9 || B[4*k +: 4] > 4'd9) inv_in = 1'b1;
    end
  end

  // 9's complement of b plus initial carry 1 gives ten's complement.
  always_comb begin
    dig_a   = a_q[3:0];
    dig_b   = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    t       = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0, c_q};
    c_nxt   = (t > 5'd9);
    // t-10 modulo 16 equals t+6 on the low nibble
    digit   = c_nxt ? (t[3:0] + 4'd6) : t[3:0];
    dig_ext = W'(digit) << (4 * (DIGITS - 1));
  end

  assign accept = start &&
                  ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    cnt_d     = cnt_q;
    sub_d     = sub_q;
    c_d       = c_q;
    inv_d     = inv_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE) state_d = ST_IDLE;
        if (accept) begin
          state_d   = ST_RUN;
          a_d       = A;
          b_d       = B;
          sub_d     = sub;
          cnt_d     = '0;
          c_d       = sub;
          inv_d     = inv_in;
          s_d       = '0;
          cout_d    = 1'b0;
          invalid_d = 1'b0;
        end
      end
      ST_RUN: begin
        s_d   = (s_q >> 4) | dig_ext;
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        c_d   = c_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d   = ST_DONE;
          cnt_d     = '0;
          cout_d    = c_nxt;
          invalid_d = inv_q;
          if (inv_q) begin
            s_d    = '0;
            cout_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      cnt_q     <= '0;
      sub_q     <= 1'b0;
      c_q       <= 1'b0;
      inv_q     <= 1'b0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      cnt_q     <= cnt_d;
      sub_q     <= sub_d;
      c_q       <= c_d;
      inv_q     <= inv_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign S       = s_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Randomized and directed bench for bcd_addsub_serial (DIGITS=4).
// Results are compared with an integer-arithmetic decimal model.
module tb_bcd_addsub_serial;

  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          sub = 1'b0;
  logic [4*D-1:0] A = '0;
  logic [4*D-1:0] B = '0;
  logic          busy;
  logic          done;
  logic [4*D-1:0] S;
  logic          cout;
  logic          invalid;

  int n_chk = 0;
  int n_pass = 0;

  bcd_addsub_serial #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .A(A), .B(B), .busy(busy), .done(done),
    .S(S), .cout(cout), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Decimal model: decode digits to integers, do the arithmetic mod 10^D.
  task automatic model(input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                       input logic s, output logic [4*D-1:0] es,
                       output logic ec, output logic ei);
    int va, vb, r, p, m;
    logic [3:0] da, db;
    va = 0; vb = 0; p = 1; ei = 1'b0;
    for (int k = 0; k < D; k++) begin
      da = a[4*k +: 4];
      db = b[4*k +: 4];
      if (da > 9 || db > 9) ei = 1'b1;
      va += int'(da) * p;
      vb += int'(db) * p;
      p *= 10;
    end
    m = p;
    if (s) begin
      r  = va - vb + m;
      ec = (va >= vb);
    end else begin
      r  = va + vb;
      ec = (r >= m);
    end
    r = r % m;
    es = '0;
    for (int k = 0; k < D; k++) begin
      es[4*k +: 4] = 4'(r % 10);
      r /= 10;
    end
    if (ei) begin
      es = '0;
      ec = 1'b0;
    end
  endtask

  // Called just after an edge; the next edge accepts the request.
  task automatic go(input logic [4*D-1:0] a, input logic [4*D-1:0] b,
                    input logic s);
    start = 1'b1; A = a; B = b; sub = s;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_e0", busy, 1);
    chk("done_e0", done, 0);
  endtask

  task automatic wait_done(input string tag, input logic [4*D-1:0] a,
                           input logic [4*D-1:0] b, input logic s);
    int n;
    logic [4*D-1:0] es;
    logic ec, ei;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (!done && n < 20) chk({tag, "_busy"}, busy, 1);
    end
    model(a, b, s, es, ec, ei);
    chk({tag, "_lat"}, n, D);
    chk({tag, "_S"}, S, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_inv"}, invalid, ei);
    chk({tag, "_bz"}, busy, 0);
  endtask

  task automatic op(input string tag, input logic [4*D-1:0] a,
                    input logic [4*D-1:0] b, input logic s);
    go(a, b, s);
    wait_done(tag, a, b, s);
  endtask

  initial begin
    logic [4*D-1:0] ra, rb;
    logic rs;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_S", S, 0);
    chk("rst_cout", cout, 0);
    chk("rst_inv", invalid, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    op("add1", 16'h1234, 16'h5678, 1'b0);
    chk("add1_val", S, 16'h6912);
    op("add2", 16'h9999, 16'h0001, 1'b0);
    chk("add2_c", cout, 1);
    op("add3", 16'h0000, 16'h0000, 1'b0);
    op("sub1", 16'h5000, 16'h1234, 1'b1);
    chk("sub1_val", S, 16'h3766);
    op("sub2", 16'h0012, 16'h0345, 1'b1);
    chk("sub2_val", S, 16'h9667);
    op("sub3", 16'h4321, 16'h4321, 1'b1);
    chk("sub3_c", cout, 1);
    op("inv1", 16'h12A4, 16'h0001, 1'b0);
    chk("inv1_flag", invalid, 1);
    op("inv_clr", 16'h0001, 16'h0001, 1'b0);

    // start during RUN is ignored
    go(16'h1234, 16'h5678, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; A = 16'h1111; B = 16'h1111; sub = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = 16'h1234; B = 16'h5678; sub = 1'b0;
    begin
      int n;
      n = 2;
      while (!done && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("ign_lat", n, D);
      chk("ign_S", S, 16'h6912);
    end
    // back-to-back start in the DONE cycle
    op("b2b", 16'h0789, 16'h0456, 1'b1);
    chk("b2b_S", S, 16'h0333);

    // async reset mid-RUN
    go(16'h1234, 16'h5678, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_S", S, 0);
    chk("arst_cout", cout, 0);
    chk("arst_inv", invalid, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    op("post_rst", 16'h0005, 16'h0005, 1'b0);
    chk("post_rst_S", S, 16'h0010);

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < D; k++) begin
        ra[4*k +: 4] = 4'($urandom_range(0, 9));
        rb[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 7) == 0)
        ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      rs = 1'($urandom_range(0, 1));
      op("rnd", ra, rb, rs);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
